// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester word-memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration).
package mem_arb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int WORDS  = 2 ** ADDR_W;

  // Controller states; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Requester indices into the req/gnt/done vectors.
  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

endpackage

// File: rtl/mem_arbiter_ctrl_rr_arbiter2.sv
// Two-way arbiter producing a one-hot winner.
// With MEM_ARB_RR_EN defined it keeps a pointer to the last winner and
// favours the other requester on a tie; otherwise requester 0 always wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] win
);

`ifdef MEM_ARB_RR_EN
  // Index of the requester granted most recently; reset to 1 so 0 goes first.
  logic last_q;

  // Pick the winner: on a tie the requester not granted last wins.
  always_comb begin
    win = '0;
    if (req[REQ0] && req[REQ1]) begin
      if (last_q) win[REQ0] = 1'b1;
      else        win[REQ1] = 1'b1;
    end else if (req[REQ0]) begin
      win[REQ0] = 1'b1;
    end else if (req[REQ1]) begin
      win[REQ1] = 1'b1;
    end
  end

  // Move the pointer to the requester that just received the grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (advance && (|req)) begin
      last_q <= win[REQ1];
    end
  end
`else
  // Fixed priority: requester 0 wins any tie, no state is kept.
  always_comb begin
    win = '0;
    if (req[REQ0])      win[REQ0] = 1'b1;
    else if (req[REQ1]) win[REQ1] = 1'b1;
  end

  // Clock, reset and advance only matter for the round-robin pointer.
  logic unused_inputs;
  assign unused_inputs = ^{clk, reset, advance};
`endif

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrated access controller for a 4-word JK-cell memory shared by two
// requesters. Each transaction is IDLE -> ACCESS -> RESP, one cycle each.
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of fixed
// priority, implemented inside rr_arbiter2).
module mem_arbiter_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 rw0,
  input  logic                 rw1,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [DATA_W-1:0]    wdata0,
  input  logic [DATA_W-1:0]    wdata1,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic [DATA_W-1:0]    rdata,
  output logic [2**ADDR_W-1:0] mem_add,
  output logic                 mem_rw,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);
  import mem_arb_pkg::*;

  localparam int WORDS = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_RESP   = RESP;

  logic [1:0]        state;
  logic [1:0]        req;
  logic [1:0]        win;
  logic              advance;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign req     = {req1, req0};
  assign advance = (state == S_IDLE);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .win     (win)
  );

  // Sequence one transaction: latch the winner's request, access, respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      gnt     <= '0;
      done    <= '0;
      rdata   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= '0;
          if (|req) begin
            gnt     <= win;
            rw_q    <= win[REQ1] ? rw1    : rw0;
            addr_q  <= win[REQ1] ? addr1  : addr0;
            wdata_q <= win[REQ1] ? wdata1 : wdata0;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // After a write the response data mirrors what was stored.
          rdata <= rw_q ? wdata_q : mem_rdata;
          done  <= gnt;
          state <= S_RESP;
        end
        S_RESP: begin
          done  <= '0;
          gnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          done  <= '0;
          gnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory strobes derive from state so an asynchronous reset kills them at once.
  always_comb begin
    mem_add = '0;
    mem_rw  = 1'b0;
    if (state == S_ACCESS) begin
      mem_add[addr_q] = 1'b1;
      mem_rw          = rw_q;
    end
  end

  assign mem_wdata = wdata_q;

  // WORDS documents the select width; tie it off for lint cleanliness.
  logic unused_words;
  assign unused_words = (WORDS == 0);

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed self-checking bench for mem_arbiter_ctrl with a behavioural
// 4x16 word memory attached to the mem_* port group.
module tb_mem_arbiter_ctrl;

  logic        clk;
  logic        reset;
  logic        req0, req1, rw0, rw1;
  logic [1:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  gnt, done;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [3:0]  mem_add;
  logic        mem_rw;

  logic [15:0] mem [4];
  int          cyc;
  int          n_cmp;
  int          n_mis;
  int          last_acc;

  mem_arbiter_ctrl #(.DATA_W(16), .ADDR_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .rw0       (rw0),
    .rw1       (rw1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .mem_add   (mem_add),
    .mem_rw    (mem_rw),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word array: write on the rising edge when selected and enabled.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_rw && mem_add[i]) mem[i] <= mem_wdata;
  end

  // Combinational read of the selected word.
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (mem_add[i]) mem_rdata = mem_rdata | mem[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from a single requester, starting in IDLE.
  task automatic txn(input logic sel, input logic rw, input logic [1:0] a,
                     input logic [15:0] d, input logic [15:0] exp_rd, input string tag);
    logic [1:0] g;
    logic [3:0] oh;
    g  = sel ? 2'b10 : 2'b01;
    oh = 4'b0001 << a;
    if (sel) begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = d; end
    else     begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = d; end
    step();
    last_acc = cyc;
    chk({tag, ".acc_gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".acc_add"}, 32'(mem_add), 32'(oh));
    chk({tag, ".acc_rw"},  32'(mem_rw), 32'(rw));
    chk({tag, ".acc_done"}, 32'(done), 32'd0);
    if (rw) chk({tag, ".acc_wdata"}, 32'(mem_wdata), 32'(d));
    step();
    chk({tag, ".resp_done"}, 32'(done), 32'(g));
    chk({tag, ".resp_rdata"}, 32'(rdata), 32'(exp_rd));
    chk({tag, ".resp_add"}, 32'({mem_add, 3'b000, mem_rw}), 32'd0);
    chk({tag, ".resp_gnt"}, 32'(gnt), 32'(g));
    if (sel) req1 = 1'b0; else req0 = 1'b0;
    step();
    chk({tag, ".idle_gnt_done"}, 32'({gnt, done}), 32'd0);
  endtask

  initial begin
    logic [1:0]  exp_g [4];
    logic [15:0] exp_rd [4];
    logic [15:0] b2b_rd [4];
    int          prev;

    n_cmp = 0; n_mis = 0; cyc = 0; last_acc = 0;
    mem[0] = 16'h0F0F; mem[1] = 16'h0000; mem[2] = 16'h3C3C; mem[3] = 16'h1234;
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    reset = 1'b1;
    #1;
    chk("rst_async_outs", 32'({gnt, done, mem_add, mem_rw}), 32'd0);
    step(); step();
    reset = 1'b0;
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    step();
    chk("idle_outs", 32'({gnt, done, mem_add, mem_rw}), 32'd0);

    // Write A5A5 to word 1 from requester 0, then read it back from requester 1.
    txn(1'b0, 1'b1, 2'd1, 16'hA5A5, 16'hA5A5, "wr0");
    chk("mem1_written", 32'(mem[1]), 32'h0000A5A5);
    txn(1'b1, 1'b0, 2'd1, 16'h0000, 16'hA5A5, "rd1");

    // Both requesters held together for four transactions.
`ifdef MEM_ARB_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_rd[0] = 16'hA5A5; exp_rd[1] = 16'h0F0F; exp_rd[2] = 16'hA5A5; exp_rd[3] = 16'h0F0F;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
    exp_rd[0] = 16'hA5A5; exp_rd[1] = 16'hA5A5; exp_rd[2] = 16'hA5A5; exp_rd[3] = 16'hA5A5;
`endif
    req0 = 1; rw0 = 0; addr0 = 2'd1;
    req1 = 1; rw1 = 0; addr1 = 2'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("tie%0d.gnt", k), 32'(gnt), 32'(exp_g[k]));
      step();
      chk($sformatf("tie%0d.done", k), 32'(done), 32'(exp_g[k]));
      chk($sformatf("tie%0d.rdata", k), 32'(rdata), 32'(exp_rd[k]));
      step();
    end
    req0 = 0; req1 = 0;
    step();
    chk("tie_after_idle", 32'({gnt, done}), 32'd0);

    // Requester 0 withdraws during ACCESS; the transaction still completes.
    req0 = 1; rw0 = 0; addr0 = 2'd2;
    step();
    req0 = 0;
    chk("drop.acc_gnt", 32'(gnt), 32'b01);
    chk("drop.acc_add", 32'(mem_add), 32'b0100);
    step();
    chk("drop.done", 32'(done), 32'b01);
    chk("drop.rdata", 32'(rdata), 32'h3C3C);
    step();
    step();
    chk("drop.no_regrant", 32'({gnt, mem_add}), 32'd0);

    // Reset lands in the ACCESS cycle of a write of FFFF to word 3.
    req1 = 1; rw1 = 1; addr1 = 2'd3; wdata1 = 16'hFFFF;
    step();
    chk("rstacc.add_before", 32'(mem_add), 32'b1000);
    chk("rstacc.rw_before", 32'(mem_rw), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstacc.add_now", 32'(mem_add), 32'd0);
    chk("rstacc.rw_gnt_now", 32'({mem_rw, gnt}), 32'd0);
    req1 = 0; rw1 = 0;
    #1 reset = 1'b0;
    step();
    chk("rstacc.no_done", 32'({done, gnt}), 32'd0);
    chk("rstacc.mem3_kept", 32'(mem[3]), 32'h1234);
    txn(1'b0, 1'b0, 2'd3, 16'h0000, 16'h1234, "rd3_after_rst");

    // Back-to-back reads of every word from requester 1, 3 cycles apart.
    b2b_rd[0] = 16'h0F0F; b2b_rd[1] = 16'hA5A5; b2b_rd[2] = 16'h3C3C; b2b_rd[3] = 16'h1234;
    prev = 0;
    for (int a = 0; a < 4; a++) begin
      txn(1'b1, 1'b0, 2'(a), 16'h0000, b2b_rd[a], $sformatf("b2b%0d", a));
      if (a > 0) chk($sformatf("b2b%0d.spacing", a), 32'(last_acc - prev), 32'd3);
      prev = last_acc;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
